// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: transmit FSM state encoding,
// parity mode encodings and a frame-length helper.
package uart_pkg;

    // Transmit FSM states, in frame order
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Parity mode encodings
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of bit periods in one frame: start + data + optional parity + stop
    function automatic int frame_ticks(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Transmit half of the UART. Accepts a byte through a start/ready handshake
// and shifts it out as start bit, data LSB first, optional parity and stop
// bits. One bit period is timed by the baud_tick strobe from the tick
// divider, which this block enables through baud_en while a frame is in flight.
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 baud_en,
    output logic                 tx
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    // With a 1-bit stop counter the last stop tick is at count 0 for one
    // stop bit and count 1 for two stop bits.
    localparam logic LAST_STOP = (STOP_BITS == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    tx_state_t              state, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]       bit_idx, bit_next;
    logic                   stop_cnt, stop_next;
    logic                   par_bit, par_next;
    logic                   done_next;
    logic                   tx_next;
    logic                   par_calc;

    // Parity of the byte being accepted; odd parity is the inverted XOR
    assign par_calc = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);

    assign tx_ready = (state == TX_IDLE);
    assign baud_en  = (state != TX_IDLE);

    // Next-state logic: every state transition except acceptance waits on baud_tick
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        bit_next   = bit_idx;
        stop_next  = stop_cnt;
        par_next   = par_bit;
        done_next  = 1'b0;
        case (state)
            TX_IDLE: begin
                if (tx_start) begin
                    shift_next = tx_data;
                    par_next   = par_calc;
                    bit_next   = '0;
                    stop_next  = 1'b0;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    bit_next   = '0;
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_IDX) begin
                        bit_next   = '0;
                        state_next = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    stop_next  = 1'b0;
                    state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        stop_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = TX_IDLE;
                    end else begin
                        stop_next = ~stop_cnt;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx can be registered with no extra lag
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            TX_IDLE:   tx_next = 1'b1;
            TX_START:  tx_next = 1'b0;
            TX_DATA:   tx_next = shift_next[0];
            TX_PARITY: tx_next = par_next;
            TX_STOP:   tx_next = 1'b1;
            default:   tx_next = 1'b1;
        endcase
    end

    // State and output registers; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= TX_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            tx_done   <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_next;
            stop_cnt  <= stop_next;
            par_bit   <= par_next;
            tx_done   <= done_next;
            tx        <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2)
// share clock, reset, tick and data; each has its own start request.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [3:0] start_v;
    logic [7:0] tx_data;
    logic [3:0] ready_v, done_v, en_v, tx_v;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         len;
        logic [11:0] frame;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_v[0]), .tx_data(tx_data),
        .tx_ready(ready_v[0]), .tx_done(done_v[0]), .baud_en(en_v[0]), .tx(tx_v[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_v[1]), .tx_data(tx_data),
        .tx_ready(ready_v[1]), .tx_done(done_v[1]), .baud_en(en_v[1]), .tx(tx_v[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_v[2]), .tx_data(tx_data),
        .tx_ready(ready_v[2]), .tx_done(done_v[2]), .baud_en(en_v[2]), .tx(tx_v[2]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(start_v[3]), .tx_data(tx_data),
        .tx_ready(ready_v[3]), .tx_done(done_v[3]), .baud_en(en_v[3]), .tx(tx_v[3]));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock with the given tick value; outputs are sampled 1 time unit after the edge
    task automatic step(input logic tick);
        baud_tick = tick;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
    endtask

    // Request a frame and check the zero-latency start bit
    task automatic applyStimulus(input int dut, input logic [7:0] data, input logic hold,
                                 input logic tick, input string name);
        tx_data      = data;
        start_v[dut] = 1'b1;
        step(tick);
        if (!hold) start_v[dut] = 1'b0;
        tx_data = ~data;
        checkOutput({name, " accept tx"}, 32'(tx_v[dut]), 32'h0);
        checkOutput({name, " accept ready/en"}, {30'h0, ready_v[dut], en_v[dut]}, 32'h1);
    endtask

    // Walk a frame with a tick every 16 clocks, recording the line level at the
    // start and end of every bit period, then check the completion edge
    task automatic captureFrame(input int dut, input int len, input logic [11:0] expected,
                                input string name);
        logic [11:0] first_bits;
        logic [11:0] last_bits;
        logic        busy_ok;
        logic        early_done;
        first_bits = '0;
        last_bits  = '0;
        busy_ok    = 1'b1;
        early_done = 1'b0;
        for (int p = 0; p < len; p++) begin
            first_bits[p] = tx_v[dut];
            for (int c = 1; c <= 16; c++) begin
                step(c == 16);
                if (c == 15) last_bits[p] = tx_v[dut];
                if (!(p == len - 1 && c == 16)) begin
                    if (done_v[dut]) early_done = 1'b1;
                    if (ready_v[dut] || !en_v[dut]) busy_ok = 1'b0;
                end
            end
        end
        checkOutput({name, " bits at period start"}, 32'(first_bits), 32'(expected));
        checkOutput({name, " bits at period end"}, 32'(last_bits), 32'(expected));
        checkOutput({name, " busy during frame"}, 32'(busy_ok), 32'h1);
        checkOutput({name, " no early done"}, 32'(early_done), 32'h0);
        checkOutput({name, " end done/ready/en/tx"},
                    {28'h0, done_v[dut], ready_v[dut], en_v[dut], tx_v[dut]}, 32'hD);
    endtask

    initial begin
        rst       = 1'b0;
        baud_tick = 1'b0;
        start_v   = 4'h0;
        tx_data   = 8'h00;

        vecs[0] = '{0, 8'hA5, frame_ticks(8, PAR_NONE, 1), 12'h34A};
        vecs[1] = '{0, 8'h00, frame_ticks(8, PAR_NONE, 1), 12'h200};
        vecs[2] = '{0, 8'hFF, frame_ticks(8, PAR_NONE, 1), 12'h3FE};
        vecs[3] = '{1, 8'hA5, frame_ticks(8, PAR_EVEN, 1), 12'h54A};
        vecs[4] = '{2, 8'hA5, frame_ticks(8, PAR_ODD, 1),  12'h74A};
        vecs[5] = '{1, 8'h01, frame_ticks(8, PAR_EVEN, 1), 12'h602};
        vecs[6] = '{2, 8'h01, frame_ticks(8, PAR_ODD, 1),  12'h402};
        vecs[7] = '{3, 8'h00, frame_ticks(8, PAR_NONE, 2), 12'h600};

        step(1'b0);
        step(1'b0);
        checkOutput("reset ready", 32'(ready_v), 32'hF);
        checkOutput("reset done", 32'(done_v), 32'h0);
        checkOutput("reset baud_en", 32'(en_v), 32'h0);
        checkOutput("reset tx", 32'(tx_v), 32'hF);
        rst = 1'b1;
        step(1'b0);

        // Table of single frames across all four configurations
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dut, vecs[i].data, 1'b0, 1'b0, $sformatf("vec%0d", i));
            captureFrame(vecs[i].dut, vecs[i].len, vecs[i].frame, $sformatf("vec%0d", i));
            step(1'b0);
            checkOutput($sformatf("vec%0d done one cycle", i), 32'(done_v[vecs[i].dut]), 32'h0);
        end

        // Ticks while idle must not move the block
        begin
            logic idle_ok;
            idle_ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
                step(1'b1);
                if (!ready_v[0] || !tx_v[0] || en_v[0] || done_v[0]) idle_ok = 1'b0;
            end
            checkOutput("idle ticks ignored", 32'(idle_ok), 32'h1);
        end

        // Tick coincident with the request: start bit still lasts a full period
        applyStimulus(0, 8'hC3, 1'b0, 1'b1, "coincident");
        captureFrame(0, frame_ticks(8, PAR_NONE, 1), 12'h386, "coincident");
        step(1'b0);

        // Back-to-back with tx_start held high
        applyStimulus(0, 8'h55, 1'b1, 1'b0, "b2b first");
        tx_data = 8'h3C;
        captureFrame(0, frame_ticks(8, PAR_NONE, 1), 12'h2AA, "b2b first");
        step(1'b0);
        checkOutput("b2b second start tx/ready/done",
                    {29'h0, tx_v[0], ready_v[0], done_v[0]}, 32'h0);
        start_v[0] = 1'b0;
        tx_data    = 8'h00;
        captureFrame(0, frame_ticks(8, PAR_NONE, 1), 12'h278, "b2b second");
        step(1'b0);

        // Reset in the middle of data bit 3 of 0xA5 (a zero bit)
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, "midreset");
        for (int i = 1; i <= 64; i++) step(i % 16 == 0);
        for (int i = 0; i < 8; i++) step(1'b0);
        checkOutput("midreset before tx", 32'(tx_v[0]), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset async tx/en/ready/done",
                    {28'h0, tx_v[0], en_v[0], ready_v[0], done_v[0]}, 32'hA);
        step(1'b0);
        step(1'b1);
        rst = 1'b1;
        checkOutput("midreset held idle", {30'h0, ready_v[0], en_v[0]}, 32'h2);
        step(1'b0);
        applyStimulus(0, 8'hFF, 1'b0, 1'b0, "after reset");
        captureFrame(0, frame_ticks(8, PAR_NONE, 1), 12'h3FE, "after reset");
        step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
